keypad_operand_entry: RTL and testbench
=======================================

Name: keypad_operand_entry

Overview:
Parametrised multi-digit operand entry for the calculator datapath. It takes the keypad column sense lines and the decoded key code, and qualifies each press/release cycle once. Digits accumulate in decimal into a binary operand, with backspace, clear and enter supported. The block sits between the keypad scanner/decoder and the ALU operand registers, and generalises the fixed two-digit capture to N digits with release debounce.

Parameters:
MAX_DIGITS, 4, maximum decimal digits accepted per operand (1..9)
WIDTH, 16, operand width in bits; must satisfy 2^WIDTH > 10^MAX_DIGITS - 1
RELEASE_CYCLES, 4, consecutive all-high Col cycles needed to qualify a release (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
Col  in  4  keypad column sense, active-low; key held when ~&Col
key_code  in  4  decoded key; valid whenever ~&Col
value  out  WIDTH  accumulated operand, binary
digit_count  out  4  digits currently in value
done  out  1  one-cycle pulse: operand committed by ENTER
overflow  out  1  sticky: a digit was rejected because count == MAX_DIGITS

Behaviour:
- Reset (async, rst_n=0): value=0, digit_count=0, done=0, overflow=0, FSM=WAIT_REL, release counter=0.
- Key codes: 0-9 digit; 10 BACKSPACE; 11 CLEAR; 12 ENTER; 13-15 ignored (still consume the press).
- FSM states:
  - IDLE: on a cycle with ~&Col, accept key_code and go to HELD. The action takes effect at that same edge, so outputs update 1 cycle after the press is first sampled.
  - HELD: stay while ~&Col. When &Col, go to WAIT_REL with counter=1.
  - WAIT_REL: while &Col, counter++. When counter == RELEASE_CYCLES, go to IDLE. Any ~&Col sample clears counter to 0 and stays in WAIT_REL (bounce is never accepted as a new key).
  - With RELEASE_CYCLES=1, HELD goes directly to IDLE on the first &Col.
- The reset state is WAIT_REL, so a key held through reset deassertion is not accepted.
- Digit d:
  - If a commit is pending (previous accepted key was ENTER): value<=d, digit_count<=1, clear pending.
  - Else if digit_count < MAX_DIGITS: value<=value*10+d, digit_count++.
  - Else: value unchanged, overflow<=1.
  - Multiply by 10 is computed at WIDTH+4 bits and truncated. No truncation occurs when the WIDTH rule holds.
- BACKSPACE: if digit_count>0, value<=value/10 (integer) and digit_count--. At 0 there is no change. Clears the pending flag.
- CLEAR: value=0, digit_count=0, overflow=0, pending cleared.
- ENTER: done=1 for exactly the next cycle. value and digit_count are held; set pending. ENTER with digit_count=0 still pulses done with value=0.
- done is registered: it is high in the single cycle following the accepting edge and low otherwise. Exactly one done pulse occurs per press, regardless of hold length.
- Only one key action per press; holding a key never auto-repeats.
- overflow is cleared only by CLEAR or reset, not by ENTER.

Decomposition:
- Package calc_keys_pkg: key code constants KEY_BKSP=10, KEY_CLR=11, KEY_ENT=12; FSM state enum {IDLE, HELD, WAIT_REL}.
- Sub-module keypad_release_filter: owns the FSM and release counter. Interface: clk, rst_n, Col, and a one-cycle output key_accept.
- The top level owns the value, count, pending, done and overflow logic.

Test Plan:
- Press 1, 2, 3, each held 3 cycles with 4-cycle release -> value=123, digit_count=3, done never asserted.
- Enter 4, 5, 6, then BACKSPACE -> value=45, digit_count=2. Two more BACKSPACE, then a third -> value=0, digit_count=0, no underflow.
- MAX_DIGITS=4: enter 9, 8, 7, 6, 5 -> value=9876, overflow=1. Then CLEAR -> value=0, overflow=0.
- Enter 7, 2, ENTER -> done high for exactly 1 cycle with value=72. Then press 5 -> value=5, digit_count=1.
- Bounce: press 3, then release for 2 cycles (RELEASE_CYCLES=4), press 8 for 1 cycle, then release for 4 cycles -> value=3; the 8 is ignored. A following clean press of 8 -> value=38.
- Hold 9, pulse rst_n low mid-hold, release rst_n while still holding, then release and press 4 -> value=4, digit_count=1. Outputs read 0 immediately on rst_n low, with no clk edge.

Source files
------------

// File: rtl/calc_keys_pkg.sv
// Key codes and release-filter states shared by
// the keypad operand entry block.
package calc_keys_pkg;

  localparam logic [3:0] KEY_BKSP = 4'd10;
  localparam logic [3:0] KEY_CLR  = 4'd11;
  localparam logic [3:0] KEY_ENT  = 4'd12;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    WAIT_REL
  } rel_state_e;

  function automatic logic is_digit(
    input logic [3:0] k
  );
    return k < 4'd10;
  endfunction

endpackage

// File: rtl/keypad_release_filter.sv
// Press/release qualifier: one accept per press,
// release needs RELEASE_CYCLES all-high samples.
module keypad_release_filter
  import calc_keys_pkg::*;
#(
  parameter int RELEASE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Col,
  output logic       key_accept
);

  localparam int CW = $clog2(RELEASE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(RELEASE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  rel_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          held;

  assign held = ~&Col;

  // Accept fires in the same cycle the press is
  // first seen so the action lands on that edge.
  assign key_accept = (state_q == IDLE) & held;

  // Release FSM; reset lands in WAIT_REL so a key
  // held through reset is never accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_REL;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (held) state_q <= HELD;
        end
        HELD: begin
          if (!held) begin
            if (RELEASE_CYCLES == 1) begin
              state_q <= IDLE;
            end else begin
              state_q <= WAIT_REL;
              cnt_q   <= CNT_ONE;
            end
          end
        end
        WAIT_REL: begin
          if (held) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= WAIT_REL;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/keypad_operand_entry.sv
// Multi-digit decimal operand entry with
// backspace, clear and enter.
module keypad_operand_entry
  import calc_keys_pkg::*;
#(
  parameter int MAX_DIGITS     = 4,
  parameter int WIDTH          = 16,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       Col,
  input  logic [3:0]       key_code,
  output logic [WIDTH-1:0] value,
  output logic [3:0]       digit_count,
  output logic             done,
  output logic             overflow
);

  localparam logic [3:0] MAXD = 4'(MAX_DIGITS);
  localparam logic [3:0] ONE4 = 4'd1;

  logic             key_accept;
  logic [WIDTH-1:0] value_q, value_d;
  logic [3:0]       count_q, count_d;
  logic             pend_q, pend_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH+3:0] ext;
  logic [WIDTH+3:0] mul10;
  logic [WIDTH-1:0] div10;

  keypad_release_filter #(
    .RELEASE_CYCLES(RELEASE_CYCLES)
  ) u_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .Col       (Col),
    .key_accept(key_accept)
  );

  // Shift-add x10 at WIDTH+4 bits, then truncate.
  assign ext   = {4'b0000, value_q};
  assign mul10 = (ext << 3) + (ext << 1)
               + {{WIDTH{1'b0}}, key_code};
  assign div10 = value_q / WIDTH'(10);

  // Next-state for operand, count and flags.
  always_comb begin
    value_d = value_q;
    count_d = count_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (key_accept) begin
      unique case (1'b1)
        is_digit(key_code): begin
          if (pend_q) begin
            value_d = WIDTH'(key_code);
            count_d = ONE4;
            pend_d  = 1'b0;
          end else if (count_q < MAXD) begin
            value_d = mul10[WIDTH-1:0];
            count_d = count_q + ONE4;
          end else begin
            ovf_d = 1'b1;
          end
        end
        (key_code == KEY_BKSP): begin
          pend_d = 1'b0;
          if (count_q != 4'd0) begin
            value_d = div10;
            count_d = count_q - ONE4;
          end
        end
        (key_code == KEY_CLR): begin
          value_d = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          pend_d  = 1'b0;
        end
        (key_code == KEY_ENT): begin
          done_d = 1'b1;
          pend_d = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Operand state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      count_q <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign value       = value_q;
  assign digit_count = count_q;
  assign done        = done_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Scoreboard bench for keypad_operand_entry:
// directed presses, monitor-side comparison.
module tb_keypad_operand_entry;
  import calc_keys_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  Col;
  logic [3:0]  key_code;
  logic [15:0] value;
  logic [3:0]  digit_count;
  logic        done;
  logic        overflow;

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  c;
    logic        o;
    logic        d;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] dq[$];
  event        chk_ev;
  int          checks;
  int          failures;
  logic        done_prev;

  keypad_operand_entry #(
    .MAX_DIGITS    (4),
    .WIDTH         (16),
    .RELEASE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Col        (Col),
    .key_code   (key_code),
    .value      (value),
    .digit_count(digit_count),
    .done       (done),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare outputs against the
  // oldest expectation when a check is due.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_empty: no expectation queued");
      end else begin
        e = sb.pop_front();
        if (value !== e.v || digit_count !== e.c ||
            overflow !== e.o || done !== e.d) begin
          failures++;
          $display("FAIL state: got v=%0d c=%0d o=%b d=%b want v=%0d c=%0d o=%b d=%b",
                   value, digit_count, overflow, done,
                   e.v, e.c, e.o, e.d);
        end
      end
    end
  end

  // Monitor: every done pulse must match a queued
  // commit value and last exactly one cycle.
  initial begin
    logic [15:0] ev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        checks++;
        if (done_prev) begin
          failures++;
          $display("FAIL done_width: done high 2 cycles, want 1");
        end else if (dq.size() == 0) begin
          failures++;
          $display("FAIL done_extra: got pulse v=%0d, want none",
                   value);
        end else begin
          ev = dq.pop_front();
          if (value !== ev) begin
            failures++;
            $display("FAIL done_value: got %0d want %0d",
                     value, ev);
          end
        end
      end
      done_prev = done;
    end
  end

  task automatic expect_now(
    input logic [15:0] v, input logic [3:0] c,
    input logic o, input logic d
  );
    exp_t e;
    e = '{v: v, c: c, o: o, d: d};
    sb.push_back(e);
    -> chk_ev;
  endtask

  task automatic press(
    input logic [3:0] k, input int hold,
    input int rel, input logic [15:0] v,
    input logic [3:0] c, input logic o
  );
    logic d;
    d = (k == KEY_ENT);
    @(negedge clk);
    Col = 4'b1110;
    key_code = k;
    if (d) dq.push_back(v);
    @(posedge clk);
    #2;
    expect_now(v, c, o, d);
    repeat (hold) @(negedge clk);
    Col = 4'hF;
    repeat (rel - 1) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    Col = 4'hF;
    key_code = 4'd0;
    #1;
    expect_now(16'd0, 4'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    press(4'd1, 3, 4, 16'd1, 4'd1, 1'b0);
    press(4'd2, 3, 4, 16'd12, 4'd2, 1'b0);
    press(4'd3, 3, 4, 16'd123, 4'd3, 1'b0);
    press(KEY_CLR, 2, 4, 16'd0, 4'd0, 1'b0);

    press(4'd4, 2, 4, 16'd4, 4'd1, 1'b0);
    press(4'd5, 2, 4, 16'd45, 4'd2, 1'b0);
    press(4'd6, 2, 4, 16'd456, 4'd3, 1'b0);
    press(KEY_BKSP, 2, 4, 16'd45, 4'd2, 1'b0);
    press(KEY_BKSP, 2, 4, 16'd4, 4'd1, 1'b0);
    press(KEY_BKSP, 2, 4, 16'd0, 4'd0, 1'b0);
    press(KEY_BKSP, 2, 4, 16'd0, 4'd0, 1'b0);

    press(4'd9, 1, 4, 16'd9, 4'd1, 1'b0);
    press(4'd8, 1, 4, 16'd98, 4'd2, 1'b0);
    press(4'd7, 1, 4, 16'd987, 4'd3, 1'b0);
    press(4'd6, 1, 4, 16'd9876, 4'd4, 1'b0);
    press(4'd5, 1, 4, 16'd9876, 4'd4, 1'b1);
    press(KEY_ENT, 2, 4, 16'd9876, 4'd4, 1'b1);
    press(4'd14, 2, 4, 16'd9876, 4'd4, 1'b1);
    press(KEY_CLR, 2, 4, 16'd0, 4'd0, 1'b0);

    press(4'd7, 2, 4, 16'd7, 4'd1, 1'b0);
    press(4'd2, 2, 4, 16'd72, 4'd2, 1'b0);
    press(KEY_ENT, 10, 4, 16'd72, 4'd2, 1'b0);
    press(4'd5, 2, 4, 16'd5, 4'd1, 1'b0);
    press(KEY_ENT, 2, 4, 16'd5, 4'd1, 1'b0);
    press(KEY_BKSP, 2, 4, 16'd0, 4'd0, 1'b0);
    press(4'd3, 2, 4, 16'd3, 4'd1, 1'b0);
    press(KEY_CLR, 2, 4, 16'd0, 4'd0, 1'b0);
    press(KEY_ENT, 2, 4, 16'd0, 4'd0, 1'b0);
    press(4'd1, 2, 4, 16'd1, 4'd1, 1'b0);
    press(KEY_CLR, 2, 4, 16'd0, 4'd0, 1'b0);

    press(4'd3, 3, 2, 16'd3, 4'd1, 1'b0);
    press(4'd8, 1, 4, 16'd3, 4'd1, 1'b0);
    press(4'd8, 2, 4, 16'd38, 4'd2, 1'b0);
    press(KEY_CLR, 2, 4, 16'd0, 4'd0, 1'b0);

    @(negedge clk);
    Col = 4'b1101;
    key_code = 4'd9;
    @(posedge clk);
    #2;
    expect_now(16'd9, 4'd1, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expect_now(16'd0, 4'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    Col = 4'hF;
    repeat (3) @(negedge clk);
    press(4'd4, 2, 4, 16'd4, 4'd1, 1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (dq.size() != 0) begin
      failures++;
      $display("FAIL done_missing: got %0d pending, want 0",
               dq.size());
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_left: got %0d pending, want 0",
               sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
